// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the front end of the 5-stage RISC-V core.
//   fetch_state_t : fetch controller FSM states (IDLE, REQ, WAIT, HOLD)
//   INSTR_NOP     : canonical NOP (addi x0, x0, 0) shown when no instruction
//   PC_STEP       : sequential fetch increment in bytes
//   word_align()  : clears the two byte-offset bits of an address
// ---------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/imem_fetch_perf.sv
// ---------------------------------------------------------------------------
// imem_fetch_perf
// Optional performance counters for the fetch controller. The module only
// exists when IMEM_FETCH_PERF_EN is defined.
// Ports:
//   clk            in   core clock
//   rst            in   synchronous active-low reset, clears both counters
//   consume_i      in   decode consumed the presented instruction this cycle
//   stall_cycle_i  in   an instruction was presented but decode stalled
//   fetch_count_o  out  consumed-instruction count (wraps)
//   stall_count_o  out  stalled-presentation cycle count (wraps)
// ---------------------------------------------------------------------------
`ifdef IMEM_FETCH_PERF_EN
module imem_fetch_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        consume_i,
  input  logic        stall_cycle_i,
  output logic [31:0] fetch_count_o,
  output logic [31:0] stall_count_o
);

  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = consume_i     ? fetch_count_q + 32'd1 : fetch_count_q;
    stall_count_d = stall_cycle_i ? stall_count_q + 32'd1 : stall_count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count_o = fetch_count_q;
  assign stall_count_o = stall_count_q;

endmodule
`endif

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction-fetch controller. Owns the fetch PC, issues one outstanding
// instruction-memory request at a time over a ready/valid handshake and
// presents each returned word with its PC to the IF/ID boundary. Absorbs
// decode stalls and EX redirects; a response belonging to a squashed fetch
// is discarded via the drop flag.
// Optional feature macro: IMEM_FETCH_PERF_EN adds fetch_count_o and
// stall_count_o (counters in imem_fetch_perf).
// Parameters:
//   RESET_PC       first fetch address after reset (word aligned)
// Ports:
//   clk            in   core clock
//   rst            in   synchronous active-low reset
//   stall_i        in   decode not accepting, hold presented instruction
//   redirect_i     in   one-cycle EX redirect strobe
//   redirect_pc_i  in   redirect target, low two bits ignored
//   InstrMemRead   out  request valid
//   InstrMemAddr   out  request address
//   InstrMemReady  in   memory accepts request this cycle
//   InstrMemValid  in   response valid
//   InstrMemData   in   response word
//   PC             out  PC of instr_o
//   instr_o        out  fetched instruction, NOP when not valid
//   instr_valid_o  out  instr_o/PC valid for decode
//   fetch_count_o  out  (IMEM_FETCH_PERF_EN) consumed instructions
//   stall_count_o  out  (IMEM_FETCH_PERF_EN) stalled presentation cycles
// ---------------------------------------------------------------------------
module imem_fetch_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        InstrMemRead,
  output logic [31:0] InstrMemAddr,
  input  logic        InstrMemReady,
  input  logic        InstrMemValid,
  input  logic [31:0] InstrMemData,
  output logic [31:0] PC,
  output logic [31:0] instr_o,
  output logic        instr_valid_o
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count_o,
  output logic [31:0] stall_count_o
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         consume;

  // A redirect takes precedence, so an instruction squashed in the same
  // cycle it would have been accepted does not count as consumed.
  assign consume = valid_q & ~stall_i & ~redirect_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;

    unique case (state_q)
      IDLE: begin
        state_d    = REQ;
        fetch_pc_d = RESET_PC;
      end

      REQ: begin
        // A request accepted together with a redirect is already stale,
        // so its response is marked for discard.
        if (InstrMemReady) begin
          state_d = WAIT;
          drop_d  = redirect_i;
        end
      end

      WAIT: begin
        // A response arriving with a redirect, or while drop is set, is
        // squashed; in either case the next fetch targets fetch_pc.
        if (InstrMemValid) begin
          if (drop_q || redirect_i) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d = InstrMemData;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect_i) begin
          drop_d = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_i) begin
          valid_d = 1'b0;
          instr_d = INSTR_NOP;
          state_d = REQ;
        end else if (consume) begin
          valid_d    = 1'b0;
          instr_d    = INSTR_NOP;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    // Redirect overrides any sequential PC update in every state.
    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      pc_q       <= RESET_PC;
      instr_q    <= INSTR_NOP;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign InstrMemRead  = (state_q == REQ);
  assign InstrMemAddr  = fetch_pc_q;
  assign PC            = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;

`ifdef IMEM_FETCH_PERF_EN
  imem_fetch_perf u_perf (
    .clk           (clk),
    .rst           (rst),
    .consume_i     (consume),
    .stall_cycle_i (valid_q & stall_i),
    .fetch_count_o (fetch_count_o),
    .stall_count_o (stall_count_o)
  );
`endif

endmodule
